rib_ex_bridge: RTL and testbench
================================

Name: rib_ex_bridge

Overview:
- Downstream of the core's execute-stage memory port (rib_ex_addr/data/req/we, rib_ex_data_i, rib_hold_flag_i).
- Converts the core's single-cycle combinational load/store request into a registered valid/ready request channel plus a read-response channel, toward slow memories and peripherals.
- Stalls the pipeline through the bus hold flag until each access completes.
- Exactly one transaction outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, cycles before an access is aborted (used only with the optional feature).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- ex_addr_i  in  ADDR_W  core access address.
- ex_data_i  in  DATA_W  core write data.
- ex_req_i  in  1  core access request; combinational from execute stage.
- ex_we_i  in  1  1 = write, 0 = read.
- ex_data_o  out  DATA_W  read data returned to the core.
- hold_flag_o  out  1  pipeline hold, to the core's bus hold input.
- m_valid_o  out  1  request valid.
- m_ready_i  in  1  request accepted by slave.
- m_addr_o  out  ADDR_W  registered request address.
- m_data_o  out  DATA_W  registered write data.
- m_we_o  out  1  registered write enable.
- s_rvalid_i  in  1  read response valid.
- s_rdata_i  in  DATA_W  read response data.
- err_o  out  1  sticky timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is asynchronous, active-low.
- Reset values: state=IDLE; m_valid_o=0; m_addr_o=0; m_data_o=0; m_we_o=0; ex_data_o=0; err_o=0; timeout counter=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On ex_req_i=1: capture ex_addr_i, ex_data_i, ex_we_i into m_addr_o, m_data_o, m_we_o; set m_valid_o=1; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - m_valid_o held 1; address and data held stable until the handshake.
  - Handshake = m_valid_o & m_ready_i. On handshake, m_valid_o←0.
  - Write: go to DONE.
  - Read: go to WAIT.
  - A response in the same cycle as the handshake is ignored; a response is only legal from the cycle after the handshake.
- WAIT:
  - On s_rvalid_i=1: ex_data_o←s_rdata_i; go to DONE.
  - s_rvalid_i in any other state is ignored.
- DONE:
  - One cycle, hold released. ex_data_o holds the captured data so the core writes back and advances.
  - Next state is IDLE unconditionally, even if ex_req_i=1. The following instruction's request is taken in IDLE one cycle later.
- hold_flag_o (combinational) = (state==IDLE & ex_req_i) | state==REQ | state==WAIT.
  - No combinational path from m_ready_i or s_rvalid_i to hold_flag_o.
- ex_data_o is a register and changes only on a read completion, or on a timeout (optional feature).
- Latency:
  - Read with m_ready_i=1 and a response in the cycle after the handshake: hold asserted for 3 cycles (IDLE, REQ, WAIT), released in DONE.
  - Write with m_ready_i=1: hold asserted for 2 cycles.
- Back-to-back requests: each costs at least one extra IDLE cycle after DONE; there is never a duplicate issue.
- Reset mid-operation: immediate return to IDLE, m_valid_o=0, hold_flag_o follows ex_req_i. A late s_rvalid_i arriving after reset is ignored.
- ex_req_i dropping while in REQ/WAIT (e.g. core flushed externally): the transaction still completes; the bridge does not abort.

Optional Feature:
- Macro: RIB_EX_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: m_valid_o←0; ex_data_o←ERR_DATA on reads (unchanged on writes); err_o←1 (sticky until reset); go to DONE.
  - A timeout in the same cycle as a handshake or response: the completion wins.
- Undefined: no counter; the bridge waits indefinitely; err_o tied 0.

Test Plan:
- Read, m_ready_i=1, response 1 cycle after handshake with s_rdata_i=32'h1234_5678 at addr 32'h1000_0004 → m_addr_o=32'h1000_0004, hold high 3 cycles, ex_data_o=32'h1234_5678 in DONE, a single m_valid_o pulse.
- Write 32'hA5A5_0001 to 32'h2000_0000 with m_ready_i low for 4 cycles → m_valid_o and m_data_o stable for 5 cycles, hold released the cycle after the handshake, m_we_o=1.
- ex_req_i held high across two reads (response data 32'h11, 32'h22) → two distinct handshakes separated by DONE and IDLE; the core sees 32'h11 then 32'h22; never three handshakes.
- Assert rst in WAIT, then pulse s_rvalid_i with 32'hFFFF_FFFF → state IDLE, ex_data_o=0, m_valid_o=0; the stray response is ignored.
- (RIB_EX_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8) read with no response → after 8 cycles ex_data_o=32'hDEAD_BEEF, err_o=1, hold released; err_o stays 1 through a subsequent good read.
- Response and timeout in the same cycle (TIMEOUT_CYCLES=8, s_rvalid_i on the 8th cycle with 32'h77) → ex_data_o=32'h77, err_o=0.

Source files
------------

// File: rtl/rib_ex_bridge.sv
// rib_ex_bridge: turns the core's single-cycle execute-stage access into a registered valid/ready request
// plus read-response channel, stalling the pipeline until completion. Define RIB_EX_BRIDGE_TIMEOUT_EN for the access timeout.
module rib_ex_bridge #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  output logic [DATA_W-1:0] ex_data_o,
  output logic              hold_flag_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_we_o,
  input  logic              s_rvalid_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_we_q, m_we_d;
  logic [DATA_W-1:0] ex_data_q, ex_data_d;
  logic              timeout_s;
  logic              abort_s;

`ifdef RIB_EX_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter runs only while an access is in flight, so it is zero on every entry to REQ.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | abort_s;
    if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_cfg_s;

  assign timeout_s    = 1'b0;
  assign unused_cfg_s = ^{abort_s, 32'(TIMEOUT_CYCLES)};
  assign err_o        = 1'b0;
`endif

  // Transaction sequencing; a handshake or response always takes priority over a timeout.
  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    m_we_d    = m_we_q;
    ex_data_d = ex_data_q;
    abort_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_req_i) begin
          m_addr_d  = ex_addr_i;
          m_data_d  = ex_data_i;
          m_we_d    = ex_we_i;
          m_valid_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (m_valid_q && m_ready_i) begin
          m_valid_d = 1'b0;
          state_d   = m_we_q ? ST_DONE : ST_WAIT;
        end else begin
          abort_s = timeout_s;
        end
      end
      ST_WAIT: begin
        if (s_rvalid_i) begin
          ex_data_d = s_rdata_i;
          state_d   = ST_DONE;
        end else begin
          abort_s = timeout_s;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_s) begin
      m_valid_d = 1'b0;
      state_d   = ST_DONE;
      if (!m_we_q) begin
        ex_data_d = ERR_DATA;
      end else begin
        ex_data_d = ex_data_q;
      end
    end else begin
      abort_s = 1'b0;
    end
  end

  // State and registered request/response fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_we_q    <= 1'b0;
      ex_data_q <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      m_we_q    <= m_we_d;
      ex_data_q <= ex_data_d;
    end
  end

  // Stall depends only on state and the core's request, never on the slave handshake.
  assign hold_flag_o = ((state_q == ST_IDLE) && ex_req_i) || (state_q == ST_REQ) || (state_q == ST_WAIT);

  assign m_valid_o = m_valid_q;
  assign m_addr_o  = m_addr_q;
  assign m_data_o  = m_data_q;
  assign m_we_o    = m_we_q;
  assign ex_data_o = ex_data_q;

endmodule

// File: tb/tb_rib_ex_bridge.sv
// tb_rib_ex_bridge: randomized scoreboard bench for rib_ex_bridge with a memory-level reference model.
// Timeout scenarios are exercised when RIB_EX_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_rib_ex_bridge;
  localparam int TO = 8;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;
  localparam logic [31:0] A = 32'h3000_0010;
  localparam logic [31:0] B = 32'h3000_0020;
  localparam logic [31:0] C = 32'h3000_0030;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] ex_addr_i, ex_data_i, ex_data_o, m_addr_o, m_data_o, s_rdata_i;
  logic ex_req_i, ex_we_i, hold_flag_o, m_valid_o, m_ready_i, m_we_o, s_rvalid_i, err_o;

  rib_ex_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i), .ex_req_i(ex_req_i),
    .ex_we_i(ex_we_i), .ex_data_o(ex_data_o), .hold_flag_o(hold_flag_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_we_o(m_we_o),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int hs_count = 0;
  int last_vlen = 0;
  int ready_delay = 0;
  int ready_pct = 100;
  int resp_delay = 1;
  bit inject_rv = 1'b0;
  logic [31:0] inject_data = 32'h0;
  logic [64:0] req_q[$];
  logic [32:0] cmp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    ex_req_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_q.delete();
    cmp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    ex_req_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Core side: present one access and stall until hold drops; returns the number of held cycles.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                         input bit chk, input bit use_exp, input logic [31:0] exp_rd, output int hold_cyc);
    logic [31:0] erd;
    erd = use_exp ? exp_rd : (ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr));
    if (we) ref_mem[addr] = data;
    req_q.push_back({we, addr, data});
    if (chk) cmp_q.push_back({we, erd});
    ex_req_i = 1'b1; ex_we_i = we; ex_addr_i = addr; ex_data_i = data;
    hold_cyc = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!hold_flag_o) break;
      hold_cyc++;
    end
    if (hold_cyc >= 60) begin
      n_checks++; n_fail++;
      $display("FAIL txn_timeout: hold still high after %0d cycles, expected release", hold_cyc);
      do_reset();
      hold_cyc = -1;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  // Slave model: ready after ready_delay valid cycles, read response resp_delay cycles after the handshake.
  initial begin : slave
    int pend; int vage; logic [31:0] pdata;
    pend = 0; vage = 0; pdata = 32'h0;
    m_ready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (rst && m_valid_o && m_ready_i) begin
        if (m_we_o) slv_mem[m_addr_o] = m_data_o;
        else begin
          pend = resp_delay;
          pdata = slv_mem.exists(m_addr_o) ? slv_mem[m_addr_o] : init_val(m_addr_o);
        end
      end
      @(posedge clk); #1;
      s_rvalid_i = 1'b0;
      s_rdata_i = $urandom;
      if (!rst) begin pend = 0; vage = 0; end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin s_rvalid_i = 1'b1; s_rdata_i = pdata; end
      end
      if (inject_rv) begin s_rvalid_i = 1'b1; s_rdata_i = inject_data; end
      vage = m_valid_o ? vage + 1 : 0;
      m_ready_i = m_valid_o && (vage > ready_delay) && (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // Request-channel monitor: fields stable while valid, each handshake matches one issued access.
  initial begin : req_mon
    logic pv; int vlen; logic [64:0] prev, cur, e;
    pv = 1'b0; vlen = 0; prev = '0;
    forever begin
      @(negedge clk);
      cur = {m_we_o, m_addr_o, m_data_o};
      if (!rst) begin
        pv = 1'b0; vlen = 0;
      end else begin
        if (m_valid_o) begin
          vlen++;
          if (pv) check("req_stable", 72'(cur), 72'(prev));
        end
        if (m_valid_o && m_ready_i) begin
          hs_count++;
          last_vlen = vlen;
          if (req_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_handshake: got request to %0h, expected none", m_addr_o);
          end else begin
            e = req_q.pop_front();
            check("req_fields", 72'(cur), 72'(e));
          end
        end
        if (!m_valid_o) vlen = 0;
        pv = m_valid_o;
        prev = cur;
      end
    end
  end

  // Core-side monitor: data seen when hold releases, and ex_data_o only moves on a response.
  initial begin : cmp_mon
    logic [31:0] model_ex, prev_ex; logic prev_rv, prev_rst; logic [32:0] e;
    model_ex = '0; prev_ex = '0; prev_rv = 1'b0; prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        model_ex = '0;
      end else begin
        if (prev_rst && (ex_data_o !== prev_ex) && (ex_data_o !== ERRV))
          check("ex_data_change_without_rvalid", 72'(prev_rv), 72'(1));
        if (ex_req_i && !hold_flag_o) begin
          if (cmp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_completion: got release with ex_data_o %0h, expected none", ex_data_o);
          end else begin
            e = cmp_q.pop_front();
            if (!e[32]) model_ex = e[31:0];
            check(e[32] ? "write_ex_data_held" : "read_data", 72'(ex_data_o), 72'(model_ex));
          end
        end
      end
      prev_ex = ex_data_o; prev_rv = s_rvalid_i; prev_rst = rst;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int h; int hs0; bit we; logic [31:0] a, d;
    ex_req_i = 1'b0; ex_we_i = 1'b0; ex_addr_i = 32'h0; ex_data_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_m_valid", 72'(m_valid_o), 72'(0));
    check("rst_m_addr", 72'(m_addr_o), 72'(0));
    check("rst_m_data", 72'(m_data_o), 72'(0));
    check("rst_m_we", 72'(m_we_o), 72'(0));
    check("rst_ex_data", 72'(ex_data_o), 72'(0));
    check("rst_err", 72'(err_o), 72'(0));
    check("rst_hold", 72'(hold_flag_o), 72'(0));
    @(posedge clk); #1;

    // Directed latency cases.
    ready_delay = 0; ready_pct = 100; resp_delay = 1;
    run_txn(1'b1, 32'h1000_0004, 32'h1234_5678, 1'b1, 1'b0, 32'h0, h);
    check("write_hold_cycles", 72'(h), 72'(2));
    hs0 = hs_count;
    run_txn(1'b0, 32'h1000_0004, 32'h0, 1'b1, 1'b1, 32'h1234_5678, h);
    check("read_hold_cycles", 72'(h), 72'(3));
    check("read_valid_len", 72'(last_vlen), 72'(1));
    check("read_one_handshake", 72'(hs_count - hs0), 72'(1));
    ready_delay = 4;
    run_txn(1'b1, 32'h2000_0000, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0, h);
    check("stalled_write_hold", 72'(h), 72'(6));
    check("stalled_write_valid_len", 72'(last_vlen), 72'(5));
    ready_delay = 0;

    // Back-to-back reads with the request held high across DONE.
    run_txn(1'b1, A, 32'h11, 1'b1, 1'b0, 32'h0, h);
    run_txn(1'b1, B, 32'h22, 1'b1, 1'b0, 32'h0, h);
    idle(1);
    hs0 = hs_count;
    run_txn(1'b0, A, 32'h0, 1'b1, 1'b1, 32'h11, h);
    run_txn(1'b0, B, 32'h0, 1'b1, 1'b1, 32'h22, h);
    idle(3);
    check("b2b_handshakes", 72'(hs_count - hs0), 72'(2));

    // Randomized traffic against the reference memory.
`ifdef RIB_EX_BRIDGE_TIMEOUT_EN
    ready_pct = 100;
`else
    ready_pct = 70;
`endif
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a = 32'h4000_0000 + 32'($urandom_range(0, 7)) * 32'd4;
      d = $urandom;
      ready_delay = int'($urandom_range(0, 2));
      resp_delay = int'($urandom_range(1, 4));
      run_txn(we, a, d, 1'b1, 1'b0, 32'h0, h);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    ready_pct = 100; ready_delay = 0;
    idle(2);

    // Request dropped mid-access: the read still completes.
    hs0 = hs_count;
    resp_delay = 4;
    req_q.push_back({1'b0, A, 32'h0});
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = A; ex_data_i = 32'h0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    ex_req_i = 1'b0;
    repeat (8) @(negedge clk);
    check("flush_read_data", 72'(ex_data_o), 72'(32'h11));
    check("flush_handshake", 72'(hs_count - hs0), 72'(1));
    check("flush_hold_low", 72'(hold_flag_o), 72'(0));
    @(posedge clk); #1;

    // Reset while waiting for a response, then a stray response.
    hs0 = hs_count;
    resp_delay = 6;
    req_q.push_back({1'b0, B, 32'h0});
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = B; ex_data_i = 32'h0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", 72'(m_valid_o), 72'(0));
    check("midrst_ex_data", 72'(ex_data_o), 72'(0));
    check("midrst_hold_follows_req", 72'(hold_flag_o), 72'(1));
    check("midrst_reached_wait", 72'(hs_count - hs0), 72'(1));
    ex_req_i = 1'b0;
    #1;
    check("midrst_hold_low", 72'(hold_flag_o), 72'(0));
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    inject_data = 32'hFFFF_FFFF;
    inject_rv = 1'b1;
    @(negedge clk);
    inject_rv = 1'b0;
    @(negedge clk);
    check("stray_rsp_ex_data", 72'(ex_data_o), 72'(0));
    check("stray_rsp_m_valid", 72'(m_valid_o), 72'(0));
    check("stray_rsp_no_handshake", 72'(hs_count - hs0), 72'(1));
    @(posedge clk); #1;

`ifdef RIB_EX_BRIDGE_TIMEOUT_EN
    resp_delay = 0;
    run_txn(1'b0, A, 32'h0, 1'b1, 1'b1, ERRV, h);
    check("timeout_hold", 72'(h), 72'(TO + 1));
    check("timeout_err_set", 72'(err_o), 72'(1));
    resp_delay = 1;
    run_txn(1'b0, A, 32'h0, 1'b1, 1'b1, 32'h11, h);
    idle(1);
    check("timeout_err_sticky", 72'(err_o), 72'(1));
    do_reset();
    check("timeout_err_cleared", 72'(err_o), 72'(0));
    run_txn(1'b1, C, 32'h77, 1'b1, 1'b0, 32'h0, h);
    resp_delay = 7;
    run_txn(1'b0, C, 32'h0, 1'b1, 1'b1, 32'h77, h);
    check("late_rsp_hold", 72'(h), 72'(TO + 1));
    idle(1);
    check("late_rsp_no_err", 72'(err_o), 72'(0));
    check("late_rsp_data", 72'(ex_data_o), 72'(32'h77));
`else
    check("err_tied_low", 72'(err_o), 72'(0));
`endif
    idle(3);
    check("req_queue_drained", 72'(req_q.size()), 72'(0));
    check("cmp_queue_drained", 72'(cmp_q.size()), 72'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
